// File: rtl/stage_pkg.sv
// stage_pkg: shared state encoding, datapath width and stage record for the stage sequencer
package stage_pkg;
    localparam int W_DEF = 64;

    typedef enum logic [2:0] {IDLE, ARM, BURN, SEPARATE, DONE} state_t;

    typedef struct packed {
        logic [W_DEF-1:0] isp;
        logic [W_DEF-1:0] init_w;
        logic [W_DEF-1:0] prop_w;
        logic [W_DEF-1:0] burn;
        logic             backward;
    } stage_t;
endpackage

// File: rtl/altitude_integrator.sv
// altitude_integrator: sample tick counter and saturating altitude accumulator
module altitude_integrator #(
    parameter int W           = 64,
    parameter int TICK_CYCLES = 10,
    parameter int DT_US       = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         run,
    input  logic         restart,
    input  logic [W-1:0] vel,
    input  logic         sub,
    output logic [W-1:0] altitude,
    output logic         tick_wrap
);
    localparam int TW = $clog2(TICK_CYCLES + 1);

    logic [TW-1:0] tick;
    logic [W-1:0]  delta;
    logic [W-1:0]  next;
    logic [W:0]    sum;

    assign tick_wrap = run && tick == TW'(TICK_CYCLES - 1);
    assign delta     = vel * W'(DT_US);
    assign sum       = {1'b0, altitude} + {1'b0, delta};
    assign next      = sub ? (altitude < delta ? '0 : altitude - delta) : (sum[W] ? '1 : sum[W-1:0]);

    // sample counter, restarted on every entry to a running state
    always_ff @(posedge clk or posedge reset)
        if (reset)
            tick <= '0;
        else
            tick <= (restart || tick_wrap) ? '0 : run ? tick + 1'b1 : tick;

    // one clamped velocity sample per tick wrap
    always_ff @(posedge clk or posedge reset)
        if (reset)
            altitude <= '0;
        else if (clear)
            altitude <= '0;
        else if (tick_wrap)
            altitude <= next;
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-stage burn sequencer driving a velocity unit and integrating altitude
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int NSTAGES     = 3,
    parameter int TICK_CYCLES = 10,
    parameter int DT_US       = 10,
    parameter int COAST_TICKS = 50,
    parameter int W           = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [2:0]   cfg_idx,
    input  logic [W-1:0] cfg_isp,
    input  logic [W-1:0] cfg_init_w,
    input  logic [W-1:0] cfg_prop_w,
    input  logic [W-1:0] cfg_burn,
    input  logic         cfg_backward,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] vel_in,
    input  logic         ign_end_in,
    output logic         stg_resetb,
    output logic [W-1:0] stg_isp,
    output logic [W-1:0] stg_init_w,
    output logic [W-1:0] stg_prop_w,
    output logic [W-1:0] stg_burn,
    output logic         stg_backward,
    output logic [2:0]   stage_idx,
    output logic [W-1:0] altitude,
    output logic [W-1:0] burnout_vel,
    output logic         busy,
    output logic         done,
    output logic         aborted
);
    localparam int CW = $clog2(COAST_TICKS + 1);

    state_t        state, state_n;
    stage_t        tbl [8];
    stage_t        cur;
    logic          arm2;
    logic [CW-1:0] coast;
    logic          tick_wrap, go, restart, last, skip, coast_end;

    assign cur        = tbl[stage_idx];
    assign skip       = cur.prop_w == '0 || cur.burn == '0;
    assign last       = stage_idx == 3'(NSTAGES - 1);
    assign coast_end  = tick_wrap && coast == CW'(COAST_TICKS - 1);
    assign cfg_ready  = state == IDLE;
    assign busy       = state == ARM || state == BURN || state == SEPARATE;
    assign done       = state == DONE;
    assign stg_resetb = state == BURN || state == SEPARATE;
    assign go         = (state == IDLE || state == DONE) && start && !abort;
    assign restart    = state_n != state && (state_n == BURN || state_n == SEPARATE);

    // next state; abort overrides every transition outside IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = go ? ARM : IDLE;
            ARM:      state_n = arm2 ? (skip ? SEPARATE : BURN) : ARM;
            BURN:     state_n = ign_end_in ? SEPARATE : BURN;
            SEPARATE: state_n = coast_end ? (last ? DONE : ARM) : SEPARATE;
            DONE:     state_n = go ? ARM : DONE;
            default:  state_n = IDLE;
        endcase
        if (abort && state != IDLE)
            state_n = DONE;
    end

    // sequencing registers: state, two-cycle ARM, stage index, abort flag, coast count
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            arm2      <= 1'b0;
            stage_idx <= '0;
            aborted   <= 1'b0;
            coast     <= '0;
        end else begin
            state     <= state_n;
            arm2      <= state == ARM && !arm2;
            stage_idx <= go ? 3'd0 : (state == SEPARATE && state_n == ARM) ? stage_idx + 3'd1 : stage_idx;
            aborted   <= go ? 1'b0 : (abort && state != IDLE) ? 1'b1 : aborted;
            coast     <= restart ? '0 : (state == SEPARATE && tick_wrap) ? coast + 1'b1 : coast;
        end

    // stage table writes, presented stage parameters and burnout latch
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < 8; i++)
                tbl[i] <= '0;
            stg_isp      <= '0;
            stg_init_w   <= '0;
            stg_prop_w   <= '0;
            stg_burn     <= '0;
            stg_backward <= 1'b0;
            burnout_vel  <= '0;
        end else begin
            if (cfg_valid && cfg_ready && {1'b0, cfg_idx} < 4'(NSTAGES))
                tbl[cfg_idx] <= {cfg_isp, cfg_init_w, cfg_prop_w, cfg_burn, cfg_backward};
            if (state == ARM) begin
                stg_isp      <= cur.isp;
                stg_init_w   <= cur.init_w;
                stg_prop_w   <= cur.prop_w;
                stg_burn     <= cur.burn;
                stg_backward <= cur.backward;
            end
            if (state == BURN && ign_end_in && !abort)
                burnout_vel <= vel_in;
        end

    altitude_integrator #(
        .W          (W),
        .TICK_CYCLES(TICK_CYCLES),
        .DT_US      (DT_US)
    ) u_integrator (
        .clk      (clk),
        .reset    (reset),
        .clear    (go),
        .run      (stg_resetb),
        .restart  (restart),
        .vel      (state == SEPARATE ? burnout_vel : vel_in),
        .sub      (stg_backward),
        .altitude (altitude),
        .tick_wrap(tick_wrap)
    );
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: randomized scoreboard bench for the stage sequencer
module tb_stage_sequencer;
    localparam int NS = 3;

    logic        clk = 0, reset = 1;
    logic        cfg_valid = 0, cfg_ready, cfg_backward = 0, start = 0, abort = 0, ign_end_in = 0;
    logic [2:0]  cfg_idx = 0, stage_idx;
    logic [63:0] cfg_isp = 0, cfg_init_w = 0, cfg_prop_w = 0, cfg_burn = 0, vel_in = 0;
    logic        stg_resetb, stg_backward, busy, done, aborted;
    logic [63:0] stg_isp, stg_init_w, stg_prop_w, stg_burn, altitude, burnout_vel;

    typedef struct {
        logic [63:0] alt;
        logic [63:0] bv;
        logic        ab;
        int          idx;
        int          armc;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    logic [63:0] t_isp[NS], t_iw[NS], t_pw[NS], t_bn[NS], vc[NS];
    bit          t_bk[NS], vr[NS];
    int          bc[NS];
    logic [63:0] m_bv = 0;

    stage_sequencer dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_isp(cfg_isp), .cfg_init_w(cfg_init_w), .cfg_prop_w(cfg_prop_w), .cfg_burn(cfg_burn),
        .cfg_backward(cfg_backward), .start(start), .abort(abort), .vel_in(vel_in), .ign_end_in(ign_end_in),
        .stg_resetb(stg_resetb), .stg_isp(stg_isp), .stg_init_w(stg_init_w), .stg_prop_w(stg_prop_w),
        .stg_burn(stg_burn), .stg_backward(stg_backward), .stage_idx(stage_idx), .altitude(altitude),
        .burnout_vel(burnout_vel), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] step(input logic [63:0] a, input logic [63:0] v, input bit back);
        logic [63:0] d;
        d = v * 64'd10;
        if (back)
            return (a < d) ? 64'd0 : a - d;
        return (a > ~d) ? '1 : a + d;
    endfunction

    task automatic do_reset();
        reset = 1; cfg_valid = 0; start = 0; abort = 0; ign_end_in = 0; vel_in = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        m_bv = 0;
        for (int s = 0; s < NS; s++) begin
            t_isp[s] = 0; t_iw[s] = 0; t_pw[s] = 0; t_bn[s] = 0; t_bk[s] = 0;
        end
        @(negedge clk);
    endtask

    task automatic wr(input int idx, input logic [63:0] isp, iw, pw, bn, input bit bk);
        cfg_valid = 1; cfg_idx = 3'(idx);
        cfg_isp = isp; cfg_init_w = iw; cfg_prop_w = pw; cfg_burn = bn; cfg_backward = bk;
        chk("cfg_ready_idle", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 0;
        if (idx < NS) begin
            t_isp[idx] = isp; t_iw[idx] = iw; t_pw[idx] = pw; t_bn[idx] = bn; t_bk[idx] = bk;
        end
    endtask

    task automatic set_stage(input int s, input logic [63:0] isp, iw, pw, bn, input bit bk,
                             input int bcy, input logic [63:0] vcst, input bit vrn);
        wr(s, isp, iw, pw, bn, bk);
        bc[s] = bcy; vc[s] = vcst; vr[s] = vrn;
    endtask

    task automatic wait_resetb(input logic val, input string nm);
        int n = 0;
        while (stg_resetb !== val && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, stg_resetb, val);
    endtask

    task automatic fly(input int ab_s, input int ab_k, input bit inj);
        logic [63:0] alt, v;
        exp_t        e;
        int          n;
        alt = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("aborted_cleared", aborted, 0);
        for (int s = 0; s < NS; s++) begin
            if (s > 0) begin
                wait_resetb(0, "arm_entry");
                chk("alt_stage_end", altitude, alt);
                chk("bvel_stage_end", burnout_vel, m_bv);
            end
            wait_resetb(1, "stage_run");
            chk("stg_isp", stg_isp, t_isp[s]);
            chk("stg_init_w", stg_init_w, t_iw[s]);
            chk("stg_prop_w", stg_prop_w, t_pw[s]);
            chk("stg_burn", stg_burn, t_bn[s]);
            chk("stg_backward", stg_backward, t_bk[s]);
            chk("stage_idx_run", stage_idx, s);
            if (t_pw[s] != 0 && t_bn[s] != 0)
                for (int k = 1; k <= bc[s]; k++) begin
                    v = vr[s] ? 64'($urandom_range(0, 50000)) : vc[s];
                    vel_in = v;
                    ign_end_in = (k == bc[s]);
                    cfg_valid = inj && s == 0 && k == 3;
                    cfg_idx = 0; cfg_isp = '1; cfg_prop_w = '1; cfg_burn = '1;
                    if (cfg_valid)
                        chk("cfg_ready_burn", cfg_ready, 0);
                    if (k % 10 == 0)
                        alt = step(alt, v, t_bk[s]);
                    if (k == bc[s])
                        m_bv = v;
                    if (s == ab_s && k == ab_k) begin
                        e = '{alt, m_bv, 1'b1, s, 2 * (s + 1)};
                        q.push_back(e);
                        abort = 1;
                        @(negedge clk);
                        abort = 0;
                        ign_end_in = 0;
                        chk("abort_done", done, 1);
                        chk("abort_flag", aborted, 1);
                        chk("abort_resetb", stg_resetb, 0);
                        chk("abort_busy", busy, 0);
                        return;
                    end
                    @(negedge clk);
                end
            cfg_valid = 0;
            ign_end_in = 1;
            vel_in = {$urandom, $urandom};
            for (int c = 0; c < 50; c++)
                alt = step(alt, m_bv, t_bk[s]);
            if (s == NS - 1) begin
                e = '{alt, m_bv, 1'b0, NS - 1, 2 * NS};
                q.push_back(e);
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    // scoreboard monitor: ARM stage order and end-of-flight results
    initial begin
        int armc = 0, ent = 0;
        bit pd = 0, pa = 0, a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                armc = 0; ent = 0; pd = 0; pa = 0;
            end else begin
                a = busy && !stg_resetb;
                if (a)
                    armc++;
                if (a && !pa) begin
                    chk("arm_stage_idx", stage_idx, ent);
                    ent++;
                end
                pa = a;
                if (done && !pd) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_unexpected got=done exp=no_flight_pending");
                    end else begin
                        e = q.pop_front();
                        chk("final_altitude", altitude, e.alt);
                        chk("final_burnout_vel", burnout_vel, e.bv);
                        chk("final_aborted", aborted, e.ab);
                        chk("final_stage_idx", stage_idx, e.idx);
                        chk("arm_low_cycles", armc, e.armc);
                    end
                    armc = 0; ent = 0;
                end
                pd = done;
            end
        end
    end

    initial begin
        #900000;
        total++; bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_resetb", stg_resetb, 0);
        chk("rst_altitude", altitude, 0);
        chk("rst_burnout_vel", burnout_vel, 0);
        chk("rst_stage_idx", stage_idx, 0);
        chk("rst_stg_isp", stg_isp, 0);
        chk("rst_stg_burn", stg_burn, 0);
        do_reset();

        for (int s = 0; s < NS; s++)
            set_stage(s, 64'(300 + s), 64'(1000 * (s + 1)), 500, 100, 0, 1000, 1000, 0);
        fly(-1, 0, 0);

        do_reset();
        set_stage(0, 11, 22, 33, 44, 0, 123, 64'h8000_0000_0000_1234, 0);
        set_stage(1, 55, 66, 0, 7, 1, 40, 999, 0);
        set_stage(2, 77, 88, 9, 0, 0, 40, 999, 0);
        wr(5, '1, '1, '1, '1, 1);
        wr(3, '1, '1, '1, '1, 1);
        fly(-1, 0, 0);

        do_reset();
        set_stage(0, 1, 2, 3, 4, 0, 10, 200, 0);
        set_stage(1, 5, 6, 7, 8, 1, 55, 5000, 0);
        set_stage(2, 9, 10, 11, 12, 0, 25, 64'h1000_0000_0000_0000, 0);
        fly(-1, 0, 0);

        do_reset();
        set_stage(0, {$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom) | 1, 64'($urandom) | 1, 0, $urandom_range(15, 200), 0, 1);
        set_stage(1, {$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom) | 1, 64'($urandom) | 1, 0, 200, 0, 1);
        set_stage(2, {$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom) | 1, 64'($urandom) | 1, 1, $urandom_range(15, 200), 0, 1);
        fly(1, 37, 0);
        fly(-1, 0, 1);
        cfg_valid = 1; cfg_idx = 1; cfg_isp = 0; cfg_prop_w = 0; cfg_burn = 0;
        chk("cfg_ready_done", cfg_ready, 0);
        @(negedge clk);
        cfg_valid = 0;
        fly(-1, 0, 0);

        do_reset();
        abort = 1; start = 1;
        @(negedge clk);
        abort = 0; start = 0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_ready", cfg_ready, 1);
        chk("idle_abort_flag", aborted, 0);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int s = 0; s < NS; s++)
                set_stage(s, {$urandom, $urandom}, {$urandom, $urandom},
                          ($urandom % 4 == 0) ? 64'd0 : 64'($urandom) + 1,
                          ($urandom % 5 == 0) ? 64'd0 : 64'($urandom) + 1,
                          1'($urandom % 2), $urandom_range(1, 150), 0, 1);
            fly(-1, 0, 0);
        end

        do_reset();
        set_stage(0, 123, 456, 789, 1011, 0, 1000, 1000, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_resetb(1, "midreset_run");
        vel_in = 1000;
        repeat (25) @(negedge clk);
        chk("midreset_alt_before", altitude, 20000);
        #2 reset = 1;
        #1;
        chk("midreset_altitude", altitude, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_resetb", stg_resetb, 0);
        chk("midreset_stg_isp", stg_isp, 0);
        chk("midreset_cfg_ready", cfg_ready, 1);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
